// File: rtl/neuron_row_mac.sv
// neuron_row_mac: streams N_INPUTS activations against weights read from an
// external BRAM (one per cycle), accumulates the signed Q16.16 products, adds
// a Q8.8 bias, rounds back to Q8.8 with saturation and optional ReLU, and
// emits one result word with a single-cycle OUT_VALID pulse.
//
// Handshake: an activation is consumed on every posedge where
// X_VALID && X_READY; X_READY is high only in RUN while fewer than N_INPUTS
// activations have been taken, and X_VALID may come and go freely.
module neuron_row_mac #(
   parameter int N_INPUTS = 28,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 16,
   parameter int ACC_W    = 40,
   parameter int RELU     = 1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     START,
   input  logic signed [DATA_W-1:0] BIAS,
   input  logic signed [DATA_W-1:0] X_DATA,
   input  logic                     X_VALID,
   output logic                     X_READY,
   output logic        [ADDR_W-1:0] W_ADDR,
   output logic                     W_EN,
   output logic                     W_WE,
   input  logic signed [DATA_W-1:0] W_DO,
   output logic signed [DATA_W-1:0] OUT_DATA,
   output logic                     OUT_VALID,
   output logic                     BUSY
);

   // count must reach N_INPUTS itself, so it is one bit wider than the address
   localparam int CNT_W  = ADDR_W + 1;
   localparam int PROD_W = 2 * DATA_W;

   localparam logic        [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic        [CNT_W-1:0] CNT_N   = CNT_W'(N_INPUTS);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_DRAIN  = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic        [CNT_W-1:0]    r_count;
   logic        [CNT_W-1:0]    w_count_inc;
   logic                       w_accept;
   logic                       w_start_pass;
   logic signed [PROD_W-1:0]   w_x_ext;
   logic signed [PROD_W-1:0]   w_w_ext;
   logic signed [PROD_W-1:0]   w_prod;
   logic signed [PROD_W-1:0]   r_prod;
   logic                       r_prod_vld;
   logic signed [ACC_W-1:0]    w_prod_ext;
   logic signed [ACC_W-1:0]    r_acc;
   logic signed [ACC_W-1:0]    w_bias_ext;
   logic signed [ACC_W-1:0]    w_sum;
   logic signed [ACC_W-1:0]    w_res;
   logic signed [DATA_W-1:0]   w_sat;
   logic signed [DATA_W-1:0]   w_final;

   assign w_start_pass = (r_state == S_IDLE) && START;
   assign w_accept     = X_VALID && X_READY;
   assign w_count_inc  = r_count + CNT_ONE;
   assign W_WE         = 1'b0;

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state: RUN leaves on the edge that takes the last activation, so the
   // final product lands in acc during DRAIN and FINISH sees a complete sum
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (START) w_state_nxt = S_RUN;
         S_RUN:    if ((r_count == CNT_N) || (w_accept && (w_count_inc == CNT_N)))
                      w_state_nxt = S_DRAIN;
         S_DRAIN:  w_state_nxt = S_FINISH;
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: BRAM enabled and activations accepted only while running
   always_comb begin
      W_EN    = 1'b0;
      X_READY = 1'b0;
      BUSY    = (r_state != S_IDLE);
      if (r_state == S_RUN) begin
         W_EN    = 1'b1;
         X_READY = (r_count < CNT_N);
      end
   end

   // Count and BRAM address; address moves only on accept so W_DO stays on W[count]
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_count <= '0;
         W_ADDR  <= '0;
      end else if (w_start_pass) begin
         r_count <= '0;
         W_ADDR  <= '0;
      end else if (w_accept) begin
         r_count <= w_count_inc;
         W_ADDR  <= w_count_inc[ADDR_W-1:0];
      end
   end

   assign w_x_ext = {{DATA_W{X_DATA[DATA_W-1]}}, X_DATA};
   assign w_w_ext = {{DATA_W{W_DO[DATA_W-1]}}, W_DO};
   assign w_prod  = w_x_ext * w_w_ext;

   // Stage 1: register the signed product of the accepted pair
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_prod     <= '0;
         r_prod_vld <= 1'b0;
      end else begin
         r_prod_vld <= w_accept;
         if (w_accept) r_prod <= w_prod;
      end
   end

   assign w_prod_ext = {{(ACC_W - PROD_W){r_prod[PROD_W-1]}}, r_prod};

   // Stage 2: accumulate qualified products; cleared when a pass begins
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)               r_acc <= '0;
      else if (w_start_pass) r_acc <= '0;
      else if (r_prod_vld)   r_acc <= r_acc + w_prod_ext;
   end

   // Bias align (Q8.8 -> Q16.16), round toward -inf, saturate, optional ReLU
   always_comb begin
      w_bias_ext = {{(ACC_W - DATA_W - 8){BIAS[DATA_W-1]}}, BIAS, 8'h00};
      w_sum      = r_acc + w_bias_ext;
      w_res      = w_sum >>> 8;
      if (w_res > SAT_MAX)      w_sat = {1'b0, {(DATA_W - 1){1'b1}}};
      else if (w_res < SAT_MIN) w_sat = {1'b1, {(DATA_W - 1){1'b0}}};
      else                      w_sat = w_res[DATA_W-1:0];
      w_final = w_sat;
      if ((RELU != 0) && w_sat[DATA_W-1]) w_final = '0;
   end

   // Result register: updated and flagged on the FINISH -> IDLE edge
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         OUT_DATA  <= '0;
         OUT_VALID <= 1'b0;
      end else begin
         OUT_VALID <= (r_state == S_FINISH);
         if (r_state == S_FINISH) OUT_DATA <= w_final;
      end
   end

endmodule

// File: tb/tb_neuron_row_mac.sv
// Directed bench for neuron_row_mac: two instances (RELU=1 and RELU=0) share
// the same stimulus, each fed by its own negedge-read BRAM model.
module tb_neuron_row_mac;

  localparam int N     = 28;
  localparam int CLK_P = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bias_in;
  logic [15:0] x_data;
  logic        x_valid;

  logic        x_ready1, w_en1, w_we1, out_valid1, busy1;
  logic [4:0]  w_addr1;
  logic [15:0] w_do1, out_data1;
  logic        x_ready0, w_en0, w_we0, out_valid0, busy0;
  logic [4:0]  w_addr0;
  logic [15:0] w_do0, out_data0;

  logic [15:0] mem [0:N-1];

  int n_vec = 0;
  int n_err = 0;

  // clock / reset block
  always #(CLK_P / 2) clk = ~clk;

  neuron_row_mac #(.RELU(1)) u_dut_relu (
    .CLK(clk), .RST(rst), .START(start), .BIAS(bias_in),
    .X_DATA(x_data), .X_VALID(x_valid), .X_READY(x_ready1),
    .W_ADDR(w_addr1), .W_EN(w_en1), .W_WE(w_we1), .W_DO(w_do1),
    .OUT_DATA(out_data1), .OUT_VALID(out_valid1), .BUSY(busy1)
  );

  neuron_row_mac #(.RELU(0)) u_dut_lin (
    .CLK(clk), .RST(rst), .START(start), .BIAS(bias_in),
    .X_DATA(x_data), .X_VALID(x_valid), .X_READY(x_ready0),
    .W_ADDR(w_addr0), .W_EN(w_en0), .W_WE(w_we0), .W_DO(w_do0),
    .OUT_DATA(out_data0), .OUT_VALID(out_valid0), .BUSY(busy0)
  );

  // BRAM models: capture address on negedge, data valid at next posedge
  initial begin
    w_do1 = '0;
    w_do0 = '0;
  end
  always @(negedge clk) if (w_en1 && w_addr1 < N) w_do1 <= mem[w_addr1];
  always @(negedge clk) if (w_en0 && w_addr0 < N) w_do0 <= mem[w_addr0];

  // checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_w(input logic [15:0] w);
    for (int i = 0; i < N; i++) mem[i] = w;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_waddr"}, {27'd0, w_addr1}, 32'd0);
    check({tag, "_wen"},   {31'd0, w_en1},   32'd0);
    check({tag, "_xrdy"},  {31'd0, x_ready1}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy1},   32'd0);
    check({tag, "_oval"},  {31'd0, out_valid1}, 32'd0);
    check({tag, "_odata"}, {16'd0, out_data1}, 32'd0);
    check({tag, "_odata_lin"}, {16'd0, out_data0}, 32'd0);
    check({tag, "_busy_lin"},  {31'd0, busy0}, 32'd0);
  endtask

  // driver: one full pass with optional X_VALID gaps, optional mid-pass
  // re-START and optional chained START on the OUT_VALID cycle
  task automatic do_pass(input bit gap, input logic [15:0] x, input logic [15:0] bias,
                         input logic [15:0] exp1, input logic [15:0] exp0,
                         input int restart_at, input bit chain, input string tag,
                         output time out_t);
    int  accepts  = 0;
    int  last_acc = 0;
    int  out_c    = -1;
    int  addr_err = 0, rdy_err = 0, busy_err = 0, we_err = 0, pair_err = 0;
    bit  seen     = 1'b0;
    bit  exp_rdy, exp_busy;
    out_t   = 0;
    x_data  = x;
    bias_in = bias;
    x_valid = 1'b0;
    start   = 1'b1;
    @(posedge clk); #1;               // edge S
    start = 1'b0;
    check({tag, "_busyS"}, {31'd0, busy1}, 32'd1);
    check({tag, "_addrS"}, {27'd0, w_addr1}, 32'd0);
    for (int c = 1; c <= 80 && !seen; c++) begin
      x_valid = gap ? (c % 2 == 1) : 1'b1;
      if (c == restart_at) start = 1'b1;
      exp_rdy = (accepts < N);
      if (x_ready1 !== exp_rdy) rdy_err++;
      if (x_valid && exp_rdy) begin
        accepts++;
        last_acc = c;
      end
      @(posedge clk); #1;             // edge S+c
      start = 1'b0;
      if (w_addr1 !== 5'(accepts)) addr_err++;
      exp_busy = !(accepts == N && c >= last_acc + 2);
      if (busy1 !== exp_busy) busy_err++;
      if (w_we1 !== 1'b0 || w_we0 !== 1'b0) we_err++;
      if (w_addr0 !== w_addr1 || out_valid0 !== out_valid1 || busy0 !== busy1) pair_err++;
      if (out_valid1 === 1'b1) begin
        seen  = 1'b1;
        out_c = c;
        out_t = $time;
        if (chain) start = 1'b1;
      end
    end
    x_valid = 1'b0;
    check({tag, "_seen"},    {31'd0, seen}, 32'd1);
    check({tag, "_accepts"}, accepts, N);
    check({tag, "_lat"},     out_c - last_acc, 2);
    if (!gap) check({tag, "_outcyc"}, out_c, 30);
    check({tag, "_odata"},     {16'd0, out_data1}, {16'd0, exp1});
    check({tag, "_odata_lin"}, {16'd0, out_data0}, {16'd0, exp0});
    check({tag, "_addrseq"}, addr_err, 0);
    check({tag, "_xready"},  rdy_err, 0);
    check({tag, "_busy"},    busy_err, 0);
    check({tag, "_wwe"},     we_err, 0);
    check({tag, "_pair"},    pair_err, 0);
  endtask

  task automatic reset_mid_pass();
    int stray = 0;
    fill_w(16'h0100);
    x_data  = 16'h0100;
    bias_in = 16'h0000;
    x_valid = 1'b1;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);       // accepts at S+1..S+10
    #1;
    check("rst_mid_addr_before", {27'd0, w_addr1}, 32'd10);
    #2 rst = 1'b1;                    // asynchronous, between edges
    #1 check_reset_outputs("rst_mid");
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid1 || out_valid0 || busy1 || busy0) stray++;
    end
    x_valid = 1'b0;
    check("rst_mid_no_out", stray, 0);
  endtask

  // test sequence and final report
  initial begin
    time t_a, t_b;
    rst     = 1'b1;
    start   = 1'b0;
    x_valid = 1'b0;
    x_data  = '0;
    bias_in = '0;
    fill_w(16'h0100);
    #23;
    check_reset_outputs("por");
    rst = 1'b0;
    @(posedge clk); #1;

    do_pass(1'b0, 16'h0100, 16'h0000, 16'h1C00, 16'h1C00, -1, 1'b0, "ones",     t_a);
    do_pass(1'b1, 16'h0100, 16'h0000, 16'h1C00, 16'h1C00, -1, 1'b0, "ones_gap", t_a);

    fill_w(16'h7FFF);
    do_pass(1'b0, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF, -1, 1'b0, "sat_pos",  t_a);
    do_pass(1'b0, 16'h8001, 16'h0000, 16'h0000, 16'h8000, -1, 1'b0, "sat_neg",  t_a);

    fill_w(16'h0000);
    do_pass(1'b0, 16'h0100, 16'hFF00, 16'h0000, 16'hFF00, -1, 1'b0, "bias_neg", t_a);
    do_pass(1'b0, 16'h0100, 16'h0280, 16'h0280, 16'h0280, -1, 1'b0, "bias_pos", t_a);

    // 28 products of -1 LSB (Q16.16) floor to -1 LSB in Q8.8
    fill_w(16'h0001);
    do_pass(1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, -1, 1'b0, "floor",    t_a);

    reset_mid_pass();
    fill_w(16'h0100);
    do_pass(1'b0, 16'h0100, 16'h0000, 16'h1C00, 16'h1C00, -1, 1'b0, "after_rst", t_a);

    do_pass(1'b0, 16'h0100, 16'h0000, 16'h1C00, 16'h1C00, 5,  1'b1, "restart_a", t_a);
    do_pass(1'b0, 16'h0100, 16'h0000, 16'h1C00, 16'h1C00, -1, 1'b0, "restart_b", t_b);
    check("b2b_period", int'((t_b - t_a) / CLK_P), 31);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
